// File: rtl/core_scheduler.sv
// ---------------------------------------------------------------------------
// core_scheduler
//
// Per-core control FSM. Walks every thread datapath of a compute core through
// FETCH -> DECODE -> REQUEST -> WAIT -> EXECUTE -> UPDATE, owns the shared
// block program counter and tells the dispatcher when a RET has retired.
//
// Ports:
//   clock           core clock, rising-edge
//   reset           asynchronous active-high reset
//   start           level launch request from the dispatcher
//   thread_count    active threads in the block (sampled only at launch)
//   fetch_done      fetcher holds a valid instruction
//   decoded_ret     current decoded instruction is RET
//   lsu_state_flat  per-thread LSU state, 2 bits per thread
//                   (00 idle, 01 requesting, 10 waiting, 11 done)
//   next_pc_flat    per-thread next PC, 8 bits per thread
//   core_state      broadcast instruction-cycle state
//   current_pc      shared block PC
//   active_mask     per-thread enable
//   done            block finished
//   retired_count   instructions retired since launch, saturating
// ---------------------------------------------------------------------------
module core_scheduler #(
    parameter int THREADS_PER_BLOCK = 4,
    parameter int TC_W              = $clog2(THREADS_PER_BLOCK) + 1
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           start,
    input  logic [TC_W-1:0]                thread_count,
    input  logic                           fetch_done,
    input  logic                           decoded_ret,
    input  logic [2*THREADS_PER_BLOCK-1:0] lsu_state_flat,
    input  logic [8*THREADS_PER_BLOCK-1:0] next_pc_flat,
    output logic [2:0]                     core_state,
    output logic [7:0]                     current_pc,
    output logic [THREADS_PER_BLOCK-1:0]   active_mask,
    output logic                           done,
    output logic [15:0]                    retired_count
);

    // Index width for selecting one thread; at least one bit so a
    // single-thread core still has a legal vector.
    localparam int IDX_W = (THREADS_PER_BLOCK > 1) ? $clog2(THREADS_PER_BLOCK) : 1;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'b000,
        ST_FETCH   = 3'b001,
        ST_DECODE  = 3'b010,
        ST_REQUEST = 3'b011,
        ST_WAIT    = 3'b100,
        ST_EXECUTE = 3'b101,
        ST_UPDATE  = 3'b110,
        ST_DONE    = 3'b111
    } SchedState;

    SchedState                    r_state;
    SchedState                    w_nextState;
    logic [7:0]                   r_pc;
    logic [THREADS_PER_BLOCK-1:0] r_activeMask;
    logic                         r_done;
    logic [15:0]                  r_retiredCount;
    logic [IDX_W-1:0]             r_lastIdx;

    logic                         w_launch;
    logic [TC_W-1:0]              w_launchCount;
    logic [TC_W-1:0]              w_launchCountM1;
    logic [THREADS_PER_BLOCK-1:0] w_launchMask;
    logic                         w_anyBusy;
    logic [7:0]                   w_nextPc;

    // Launch decode: clamp the requested thread count to the core size and
    // build the matching contiguous enable mask. The highest active thread
    // index is remembered because it supplies the block PC (no divergence).
    always_comb begin
        w_launch        = (r_state == ST_IDLE) && start && (thread_count != '0);
        w_launchCount   = (thread_count > TC_W'(THREADS_PER_BLOCK)) ?
                          TC_W'(THREADS_PER_BLOCK) : thread_count;
        w_launchCountM1 = w_launchCount - 1'b1;
        w_launchMask    = '0;
        for (int i = 0; i < THREADS_PER_BLOCK; i++) begin
            w_launchMask[i] = (TC_W'(i) < w_launchCount);
        end
    end

    // A thread is still busy while its LSU is requesting (01) or waiting
    // (10); those are exactly the codes whose two bits differ. Idle and done
    // both count as complete, and inactive threads never hold the core.
    always_comb begin
        w_anyBusy = 1'b0;
        for (int i = 0; i < THREADS_PER_BLOCK; i++) begin
            if (r_activeMask[i] && (lsu_state_flat[2*i+1] ^ lsu_state_flat[2*i])) begin
                w_anyBusy = 1'b1;
            end
        end
    end

    // Pick the next PC reported by the highest active thread.
    always_comb begin
        w_nextPc = '0;
        for (int i = 0; i < THREADS_PER_BLOCK; i++) begin
            if (IDX_W'(i) == r_lastIdx) begin
                w_nextPc = next_pc_flat[8*i +: 8];
            end
        end
    end

    // Next-state logic of the instruction-cycle FSM. start is only looked at
    // in IDLE and DONE; every other state ignores it.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            ST_IDLE:    if (w_launch)    w_nextState = ST_FETCH;
            ST_FETCH:   if (fetch_done)  w_nextState = ST_DECODE;
            ST_DECODE:                   w_nextState = ST_REQUEST;
            ST_REQUEST:                  w_nextState = ST_WAIT;
            ST_WAIT:    if (!w_anyBusy)  w_nextState = ST_EXECUTE;
            ST_EXECUTE:                  w_nextState = ST_UPDATE;
            ST_UPDATE:  w_nextState = decoded_ret ? ST_DONE : ST_FETCH;
            ST_DONE:    if (!start)      w_nextState = ST_IDLE;
            default:                     w_nextState = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Block-level registers. A launch clears the per-block history; UPDATE
    // retires one instruction and either finishes the block on RET (PC held)
    // or advances the PC. done and the retire count deliberately survive the
    // DONE -> IDLE return so the dispatcher can still read them.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_pc           <= '0;
            r_activeMask   <= '0;
            r_done         <= 1'b0;
            r_retiredCount <= '0;
            r_lastIdx      <= '0;
        end else if (w_launch) begin
            r_pc           <= '0;
            r_activeMask   <= w_launchMask;
            r_done         <= 1'b0;
            r_retiredCount <= '0;
            r_lastIdx      <= w_launchCountM1[IDX_W-1:0];
        end else if (r_state == ST_UPDATE) begin
            if (r_retiredCount != 16'hFFFF) begin
                r_retiredCount <= r_retiredCount + 16'd1;
            end
            if (decoded_ret) begin
                r_done <= 1'b1;
            end else begin
                r_pc <= w_nextPc;
            end
        end
    end

    assign core_state    = r_state;
    assign current_pc    = r_pc;
    assign active_mask   = r_activeMask;
    assign done          = r_done;
    assign retired_count = r_retiredCount;

endmodule

// File: tb/tb_core_scheduler.sv
// ---------------------------------------------------------------------------
// tb_core_scheduler
//
// Directed bench for core_scheduler with THREADS_PER_BLOCK = 4. Inputs are
// driven 1 ns after each rising edge and outputs are checked at the same
// point, so nothing is sampled on the active edge.
// ---------------------------------------------------------------------------
module tb_core_scheduler;

    localparam int T    = 4;
    localparam int TC_W = $clog2(T) + 1;

    localparam logic [2:0] S_IDLE    = 3'b000;
    localparam logic [2:0] S_FETCH   = 3'b001;
    localparam logic [2:0] S_DECODE  = 3'b010;
    localparam logic [2:0] S_REQUEST = 3'b011;
    localparam logic [2:0] S_WAIT    = 3'b100;
    localparam logic [2:0] S_EXECUTE = 3'b101;
    localparam logic [2:0] S_UPDATE  = 3'b110;
    localparam logic [2:0] S_DONE    = 3'b111;

    logic             clock;
    logic             reset;
    logic             start;
    logic [TC_W-1:0]  thread_count;
    logic             fetch_done;
    logic             decoded_ret;
    logic [2*T-1:0]   lsu_state_flat;
    logic [8*T-1:0]   next_pc_flat;
    logic [2:0]       core_state;
    logic [7:0]       current_pc;
    logic [T-1:0]     active_mask;
    logic             done;
    logic [15:0]      retired_count;

    int checks = 0;
    int errors = 0;

    core_scheduler #(
        .THREADS_PER_BLOCK(T)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .start         (start),
        .thread_count  (thread_count),
        .fetch_done    (fetch_done),
        .decoded_ret   (decoded_ret),
        .lsu_state_flat(lsu_state_flat),
        .next_pc_flat  (next_pc_flat),
        .core_state    (core_state),
        .current_pc    (current_pc),
        .active_mask   (active_mask),
        .done          (done),
        .retired_count (retired_count)
    );

    // 10 ns clock
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Drive the full input vector at once
    task automatic applyStimulus(input logic st, input logic [TC_W-1:0] tc,
                                 input logic fd, input logic ret,
                                 input logic [2*T-1:0] lsu, input logic [8*T-1:0] npc);
        start          = st;
        thread_count   = tc;
        fetch_done     = fd;
        decoded_ret    = ret;
        lsu_state_flat = lsu;
        next_pc_flat   = npc;
    endtask

    // Advance to 1 ns after the next rising edge
    task automatic advanceClock();
        @(posedge clock);
        #1;
    endtask

    // One comparison
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic checkAll(input string tag, input logic [2:0] st, input logic [7:0] pc,
                            input logic [T-1:0] mask, input logic dn, input logic [15:0] ret);
        checkOutput({tag, ".state"},   32'(core_state),    32'(st));
        checkOutput({tag, ".pc"},      32'(current_pc),    32'(pc));
        checkOutput({tag, ".mask"},    32'(active_mask),   32'(mask));
        checkOutput({tag, ".done"},    32'(done),          32'(dn));
        checkOutput({tag, ".retired"}, 32'(retired_count), 32'(ret));
    endtask

    initial begin
        reset = 1'b1;
        applyStimulus(1'b0, 3'd0, 1'b0, 1'b0, 8'h00, 32'h0);
        advanceClock();
        advanceClock();
        checkAll("reset", S_IDLE, 8'h00, 4'h0, 1'b0, 16'd0);
        reset = 1'b0;

        // Launch with a full block
        applyStimulus(1'b1, 3'd4, 1'b1, 1'b0, 8'h00, 32'h01010101);
        advanceClock();
        checkAll("launch4", S_FETCH, 8'h00, 4'hF, 1'b0, 16'd0);
        start = 1'b0;

        // Straight-line instruction, minimum latency
        advanceClock(); checkOutput("seq.decode",  32'(core_state), 32'(S_DECODE));
        advanceClock(); checkOutput("seq.request", 32'(core_state), 32'(S_REQUEST));
        advanceClock(); checkOutput("seq.wait",    32'(core_state), 32'(S_WAIT));
        advanceClock(); checkOutput("seq.execute", 32'(core_state), 32'(S_EXECUTE));
        advanceClock(); checkOutput("seq.update",  32'(core_state), 32'(S_UPDATE));
        checkOutput("seq.pcBeforeUpdate", 32'(current_pc), 32'h00);
        advanceClock();
        checkAll("seq.refetch", S_FETCH, 8'h01, 4'hF, 1'b0, 16'd1);

        // LSU stall on thread 2: 01 x2, 10 x3, then 11 -> 6 WAIT cycles
        next_pc_flat = 32'h10101010;
        advanceClock(); checkOutput("stall.decode",  32'(core_state), 32'(S_DECODE));
        advanceClock(); checkOutput("stall.request", 32'(core_state), 32'(S_REQUEST));
        advanceClock();
        for (int c = 1; c <= 6; c++) begin
            if (c <= 2)      lsu_state_flat = 8'b00_01_00_00;
            else if (c <= 5) lsu_state_flat = 8'b00_10_00_00;
            else             lsu_state_flat = 8'b00_11_00_00;
            checkOutput($sformatf("stall.wait%0d", c), 32'(core_state), 32'(S_WAIT));
            advanceClock();
        end
        checkOutput("stall.execute", 32'(core_state), 32'(S_EXECUTE));
        lsu_state_flat = 8'h00;
        advanceClock(); checkOutput("stall.update", 32'(core_state), 32'(S_UPDATE));
        advanceClock();
        checkAll("stall.refetch", S_FETCH, 8'h10, 4'hF, 1'b0, 16'd2);

        // RET retires: block finishes with PC held
        decoded_ret  = 1'b1;
        next_pc_flat = 32'hEEEEEEEE;
        repeat (5) advanceClock();
        checkOutput("ret.update", 32'(core_state), 32'(S_UPDATE));
        advanceClock();
        checkAll("ret.done", S_DONE, 8'h10, 4'hF, 1'b1, 16'd3);
        start = 1'b1;
        advanceClock();
        checkOutput("ret.holdDone", 32'(core_state), 32'(S_DONE));
        start = 1'b0;
        advanceClock();
        checkAll("ret.idle", S_IDLE, 8'h10, 4'hF, 1'b1, 16'd3);

        // thread_count = 0 launch is ignored
        applyStimulus(1'b1, 3'd0, 1'b1, 1'b0, 8'h00, 32'h0);
        advanceClock();
        checkAll("tc0.ignored", S_IDLE, 8'h10, 4'hF, 1'b1, 16'd3);

        // Relaunch with 3 threads; stall on inactive thread 3 is ignored
        applyStimulus(1'b1, 3'd3, 1'b1, 1'b0, 8'h00, 32'h00330000);
        advanceClock();
        checkAll("launch3", S_FETCH, 8'h00, 4'b0111, 1'b0, 16'd0);
        start = 1'b0;
        advanceClock();
        advanceClock();
        lsu_state_flat = 8'b01_00_00_00;
        advanceClock();
        checkOutput("inactive.wait", 32'(core_state), 32'(S_WAIT));
        lsu_state_flat = 8'b10_00_00_00;
        advanceClock();
        checkOutput("inactive.execute", 32'(core_state), 32'(S_EXECUTE));
        lsu_state_flat = 8'h00;
        advanceClock();
        advanceClock();
        checkAll("tc3.pcThread2", S_FETCH, 8'h33, 4'b0111, 1'b0, 16'd1);

        // Reset in the middle of WAIT with a busy LSU
        advanceClock();
        advanceClock();
        lsu_state_flat = 8'b00_00_00_10;
        advanceClock();
        checkOutput("midReset.inWait", 32'(core_state), 32'(S_WAIT));
        #2;
        reset = 1'b1;
        #1;
        checkAll("midReset", S_IDLE, 8'h00, 4'h0, 1'b0, 16'd0);
        #1;
        reset = 1'b0;

        // Partial block, PC taken from thread 1 rather than thread 3
        applyStimulus(1'b1, 3'd2, 1'b1, 1'b0, 8'h00, 32'h55002A00);
        advanceClock();
        checkAll("launch2", S_FETCH, 8'h00, 4'b0011, 1'b0, 16'd0);
        start = 1'b0;
        repeat (6) advanceClock();
        checkAll("tc2.pcThread1", S_FETCH, 8'h2A, 4'b0011, 1'b0, 16'd1);

        // Oversized thread_count clamps; FETCH holds until fetch_done
        reset = 1'b1;
        advanceClock();
        reset = 1'b0;
        applyStimulus(1'b1, 3'd7, 1'b0, 1'b0, 8'h00, 32'h0);
        advanceClock();
        checkAll("launch7", S_FETCH, 8'h00, 4'hF, 1'b0, 16'd0);
        start = 1'b0;
        advanceClock();
        checkOutput("fetchHold1", 32'(core_state), 32'(S_FETCH));
        advanceClock();
        checkOutput("fetchHold2", 32'(core_state), 32'(S_FETCH));
        fetch_done = 1'b1;
        advanceClock();
        checkOutput("fetchRelease", 32'(core_state), 32'(S_DECODE));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
